dpwm_freq_controller: RTL and testbench
=======================================

Name: dpwm_freq_controller

Overview:
- Sequences the DPWM frequency-code lookup memory. This memory maps a 3-bit index to an 8-bit period code with 1 cycle of registered latency: 0→30, 1→50, 2→75, 3→100, 4→125, 5→150, 6→175, 7→200.
- Turns user up/down requests into index steps and waits out the memory latency.
- Applies the fetched code to the PWM period register only at a PWM period boundary, so the output never glitches.
- Sits between the debounced button logic, the lookup memory and the PWM counter.

Parameters:
- IDX_W, 3, width of the frequency index.
- CODE_W, 8, width of the period code.
- MEM_LAT, 1, cycles from an index change to a valid code on frecuencia.
- DEFAULT_IDX, 0, index loaded at reset.
- TIMEOUT_CYC, 1023, WAIT_BND cycles before a forced apply; 0 disables the timeout.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- btn_up  input  1  debounced level; a rising edge requests index+1.
- btn_down  input  1  debounced level; a rising edge requests index-1.
- period_end  input  1  single-cycle pulse from the PWM counter on its last count.
- frecuencia  input  CODE_W  code returned by the lookup memory.
- num_frecuencia  output  IDX_W  index driven to the lookup memory (registered).
- periodo  output  CODE_W  applied period code for the PWM counter (registered).
- load  output  1  single-cycle pulse in the cycle after periodo updates.
- busy  output  1  high from an accepted request until its apply.
- at_min, at_max  output  1  num_frecuencia==0 / ==2^IDX_W-1.

Behaviour:
- Reset state:
  - num_frecuencia=DEFAULT_IDX, periodo=0, load=0, busy=1, pending cleared.
  - Edge-detect history registers set to 1, so a button held through reset produces no request.
  - FSM enters FETCH with the startup flag set.
- RESET asserted mid-operation aborts everything and restarts the sequence above.
- FSM states: IDLE, FETCH, WAIT_BND, APPLY.
- IDLE:
  - Rising edge on btn_up only: if not at_max, num_frecuencia+=1, busy=1, go FETCH; if at_max, no change.
  - Rising edge on btn_down only: same, with −1 and at_min.
  - Both edges in the same cycle: ignored.
  - A valid pending request is served before live edges and is then cleared.
- FETCH:
  - Wait counter runs; frecuencia is captured into the hold register on the (MEM_LAT+1)-th rising edge after num_frecuencia changed.
  - Reset release counts as that change.
  - After capture: go APPLY if the startup flag is set, otherwise go WAIT_BND.
  - period_end in FETCH or in the capture cycle is ignored.
- WAIT_BND:
  - On the first edge with period_end=1, go APPLY.
  - If TIMEOUT_CYC≠0 and TIMEOUT_CYC cycles elapse in WAIT_BND without period_end, go APPLY.
- APPLY (one cycle):
  - periodo<=hold, load=1 the following cycle, busy=0, startup flag cleared, go IDLE.
- Latency:
  - Startup: periodo is valid MEM_LAT+3 edges after RESET deasserts.
  - Normal request with MEM_LAT=1: press edge → FETCH 2 cycles → WAIT_BND ≥1 → APPLY 1.
- Requests while busy: one-deep pending slot.
  - A new single-direction edge overwrites the slot.
  - A simultaneous up+down edge clears the slot.
  - Saturation is checked when the request is served, not when it is stored.
- Saturation: the index never wraps (7+1 stays 7, 0−1 stays 0); a saturated request is dropped silently and busy stays 0.
- at_min/at_max are combinational compares of num_frecuencia.
- periodo changes only in APPLY; load is never asserted otherwise.

Test Plan:
- Release RESET with DEFAULT_IDX=0 and no period_end → periodo=30 and load pulses exactly once, MEM_LAT+3 cycles after release; busy then low.
- In IDLE at index 0, rising edge on btn_up, period_end pulsed 10 cycles later → num_frecuencia=1 and periodo holds 30 until the boundary edge; periodo=50 afterwards with one load pulse.
- Drive index to 7 (periodo=200), then btn_up edge → no index change, busy stays 0, no load. Drive index to 0, then btn_down edge → same.
- btn_up and btn_down rise in the same IDLE cycle → no state change. btn_up rise while in WAIT_BND (index 2→3) → after the apply of 100, a second fetch runs automatically and periodo=125.
- No period_end after a request, TIMEOUT_CYC=16 → forced apply 16 cycles after entering WAIT_BND. With TIMEOUT_CYC=0 → no apply until period_end.
- Assert RESET for 1 cycle during WAIT_BND at index 5 → periodo=0 and num_frecuencia=DEFAULT_IDX, then startup load of 30. A button held high through reset generates no request.

Source files
------------

// File: rtl/dpwm_freq_controller.sv
// DPWM frequency controller: turns button edges into lookup-memory index steps,
// waits out the memory latency and applies the fetched period code on a PWM boundary.
module dpwm_freq_controller #(
  parameter int IDX_W       = 3,
  parameter int CODE_W      = 8,
  parameter int MEM_LAT     = 1,
  parameter int DEFAULT_IDX = 0,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              period_end,
  input  logic [CODE_W-1:0] frecuencia,
  output logic [IDX_W-1:0]  num_frecuencia,
  output logic [CODE_W-1:0] periodo,
  output logic              load,
  output logic              busy,
  output logic              at_min,
  output logic              at_max
);

  localparam int LAT_W = $clog2(MEM_LAT + 2) + 1;
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(MEM_LAT + 1);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) + 1 : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_BND = 2'd2,
    APPLY    = 2'd3
  } state_t;

  state_t            state;
  logic              up_prev;
  logic              down_prev;
  logic              pend_valid;
  logic              pend_up;
  logic              startup;
  logic [LAT_W-1:0]  lat_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [CODE_W-1:0] hold;

  logic              rise_up;
  logic              rise_down;
  logic              req_valid;
  logic              req_up;
  logic              req_blocked;
  logic [IDX_W-1:0]  step_idx;
  logic              timeout_hit;

  assign at_min = (num_frecuencia == '0);
  assign at_max = (num_frecuencia == {IDX_W{1'b1}});

  assign rise_up   = btn_up & ~up_prev;
  assign rise_down = btn_down & ~down_prev;

  assign timeout_hit = TO_EN && (to_cnt == TO_LAST);

  // The stored request always wins over a live edge; saturation is judged here, at service time.
  always_comb begin
    req_valid = 1'b0;
    req_up    = 1'b0;
    if (pend_valid) begin
      req_valid = 1'b1;
      req_up    = pend_up;
    end else if (rise_up ^ rise_down) begin
      req_valid = 1'b1;
      req_up    = rise_up;
    end
    req_blocked = req_up ? at_max : at_min;
    step_idx    = req_up ? num_frecuencia + IDX_W'(1) : num_frecuencia - IDX_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= FETCH;
      num_frecuencia <= IDX_W'(DEFAULT_IDX);
      periodo        <= '0;
      load           <= 1'b0;
      busy           <= 1'b1;
      pend_valid     <= 1'b0;
      pend_up        <= 1'b0;
      startup        <= 1'b1;
      lat_cnt        <= '0;
      to_cnt         <= '0;
      hold           <= '0;
      up_prev        <= 1'b1;
      down_prev      <= 1'b1;
    end else begin
      up_prev   <= btn_up;
      down_prev <= btn_down;
      load      <= 1'b0;

      // One-deep slot for requests that arrive while a change is in flight.
      if (state != IDLE) begin
        if (rise_up && rise_down) begin
          pend_valid <= 1'b0;
        end else if (rise_up || rise_down) begin
          pend_valid <= 1'b1;
          pend_up    <= rise_up;
        end
      end

      case (state)
        IDLE: begin
          pend_valid <= 1'b0;
          if (req_valid && !req_blocked) begin
            num_frecuencia <= step_idx;
            busy           <= 1'b1;
            lat_cnt        <= LAT_W'(1);
            state          <= FETCH;
          end
        end

        FETCH: begin
          if (lat_cnt == LAT_DONE) begin
            hold   <= frecuencia;
            to_cnt <= '0;
            state  <= startup ? APPLY : WAIT_BND;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        WAIT_BND: begin
          if (period_end || timeout_hit) begin
            state <= APPLY;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        APPLY: begin
          periodo <= hold;
          load    <= 1'b1;
          busy    <= 1'b0;
          startup <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpwm_freq_controller.sv
// Directed bench for dpwm_freq_controller: cycle vectors from a table plus index walks,
// with a behavioural model of the registered frequency lookup memory.
module tb_dpwm_freq_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       btn_up, btn_down, period_end;
  logic [7:0] frecuencia;
  logic [2:0] num_frecuencia;
  logic [7:0] periodo;
  logic       load, busy, at_min, at_max;

  logic       up0, down0, pe0;
  logic [7:0] frec0;
  logic [2:0] num0;
  logic [7:0] per0;
  logic       load0, busy0, min0, max0;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  function automatic logic [7:0] code_of(input logic [2:0] idx);
    case (idx)
      3'd0: code_of = 8'd30;
      3'd1: code_of = 8'd50;
      3'd2: code_of = 8'd75;
      3'd3: code_of = 8'd100;
      3'd4: code_of = 8'd125;
      3'd5: code_of = 8'd150;
      3'd6: code_of = 8'd175;
      3'd7: code_of = 8'd200;
      default: code_of = 8'd0;
    endcase
  endfunction

  // Lookup memories with one cycle of registered latency
  always @(posedge CLK) frecuencia <= code_of(num_frecuencia);
  always @(posedge CLK) frec0 <= code_of(num0);

  dpwm_freq_controller #(.TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RESET(RESET), .btn_up(btn_up), .btn_down(btn_down),
    .period_end(period_end), .frecuencia(frecuencia),
    .num_frecuencia(num_frecuencia), .periodo(periodo), .load(load),
    .busy(busy), .at_min(at_min), .at_max(at_max)
  );

  dpwm_freq_controller #(.TIMEOUT_CYC(0)) dut_noto (
    .CLK(CLK), .RESET(RESET), .btn_up(up0), .btn_down(down0),
    .period_end(pe0), .frecuencia(frec0),
    .num_frecuencia(num0), .periodo(per0), .load(load0),
    .busy(busy0), .at_min(min0), .at_max(max0)
  );

  typedef struct {
    logic       rst;
    logic       up;
    logic       dn;
    logic       pe;
    int         reps;
    logic [2:0] e_idx;
    logic [7:0] e_per;
    logic       e_load;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic up, input logic dn, input logic pe,
                     input int reps, input logic [2:0] ei, input logic [7:0] ep,
                     input logic el, input logic eb);
    vec_t v;
    v.rst = rst; v.up = up; v.dn = dn; v.pe = pe; v.reps = reps;
    v.e_idx = ei; v.e_per = ep; v.e_load = el; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] ei, input logic [7:0] ep,
                     input logic el, input logic eb);
    logic [14:0] act;
    logic [14:0] exp;
    exp = {ei, ep, el, eb, (ei == 3'd0), (ei == 3'd7)};
    act = {num_frecuencia, periodo, load, busy, at_min, at_max};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got idx=%0d per=%0d load=%b busy=%b min=%b max=%b, want idx=%0d per=%0d load=%b busy=%b min=%b max=%b",
               tag, act[14:12], act[11:4], act[3], act[2], act[1], act[0],
               exp[14:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      RESET = vecs[i].rst; btn_up = vecs[i].up; btn_down = vecs[i].dn; period_end = vecs[i].pe;
      for (int r = 0; r < vecs[i].reps; r++) begin
        tick();
        chk($sformatf("vec%0d_rep%0d", i, r), vecs[i].e_idx, vecs[i].e_per,
            vecs[i].e_load, vecs[i].e_busy);
      end
      $display("vec %0d: rst=%b up=%b dn=%b pe=%b x%0d -> idx=%0d per=%0d",
               i, vecs[i].rst, vecs[i].up, vecs[i].dn, vecs[i].pe, vecs[i].reps,
               num_frecuencia, periodo);
    end
  endtask

  // One full request: press, release, period_end held through the capture cycle (ignored there).
  task automatic step_req(input logic dir_up, input logic [2:0] ni);
    logic [2:0] oi;
    logic [7:0] op;
    logic [7:0] np;
    oi = dir_up ? ni - 3'd1 : ni + 3'd1;
    op = code_of(oi);
    np = code_of(ni);
    btn_up = dir_up; btn_down = ~dir_up;
    tick(); chk("walk_press", ni, op, 1'b0, 1'b1);
    btn_up = 1'b0; btn_down = 1'b0;
    tick(); chk("walk_fetch", ni, op, 1'b0, 1'b1);
    period_end = 1'b1;
    tick(); chk("walk_capture", ni, op, 1'b0, 1'b1);
    tick(); chk("walk_boundary", ni, op, 1'b0, 1'b1);
    period_end = 1'b0;
    tick(); chk("walk_apply", ni, np, 1'b1, 1'b0);
    tick(); chk("walk_idle", ni, np, 1'b0, 1'b0);
    $display("walk %s -> idx=%0d per=%0d", dir_up ? "up" : "down", num_frecuencia, periodo);
  endtask

  task automatic chk0(input string tag, input logic [2:0] ei, input logic [7:0] ep,
                      input logic el, input logic eb);
    logic [11:0] act;
    logic [11:0] exp;
    exp = {ei, ep, eb};
    act = {num0, per0, busy0};
    checks++;
    if (act !== exp || load0 !== el) begin
      failures++;
      $display("FAIL %s: got idx=%0d per=%0d load=%b busy=%b, want idx=%0d per=%0d load=%b busy=%b",
               tag, num0, per0, load0, busy0, ei, ep, el, eb);
    end
  endtask

  int b1, b2, b3, b4;

  initial begin
    // Reset, startup apply, then one request with period_end 10 cycles after the press
    add(1,0,0,0, 2, 3'd0, 8'd0,   0,1);
    add(0,0,0,0, 3, 3'd0, 8'd0,   0,1);
    add(0,0,0,0, 1, 3'd0, 8'd30,  1,0);
    add(0,0,0,0, 2, 3'd0, 8'd30,  0,0);
    add(0,1,0,0, 1, 3'd1, 8'd30,  0,1);
    add(0,0,0,0, 2, 3'd1, 8'd30,  0,1);
    add(0,0,0,0, 7, 3'd1, 8'd30,  0,1);
    add(0,0,0,1, 1, 3'd1, 8'd30,  0,1);
    add(0,0,0,0, 1, 3'd1, 8'd50,  1,0);
    add(0,0,0,0, 1, 3'd1, 8'd50,  0,0);
    b1 = vecs.size();
    // Saturation at the top
    add(0,1,0,0, 3, 3'd7, 8'd200, 0,0);
    add(0,0,0,0, 2, 3'd7, 8'd200, 0,0);
    b2 = vecs.size();
    // Saturation at the bottom, then simultaneous edges
    add(0,0,1,0, 3, 3'd0, 8'd30,  0,0);
    add(0,0,0,0, 1, 3'd0, 8'd30,  0,0);
    add(0,1,1,0, 3, 3'd0, 8'd30,  0,0);
    add(0,0,0,0, 2, 3'd0, 8'd30,  0,0);
    b3 = vecs.size();
    // Pending request served after apply (2->3->4)
    add(0,1,0,0, 1, 3'd3, 8'd75,  0,1);
    add(0,0,0,0, 2, 3'd3, 8'd75,  0,1);
    add(0,1,0,0, 1, 3'd3, 8'd75,  0,1);
    add(0,0,0,1, 1, 3'd3, 8'd75,  0,1);
    add(0,0,0,0, 1, 3'd3, 8'd100, 1,0);
    add(0,0,0,0, 1, 3'd4, 8'd100, 0,1);
    add(0,0,0,0, 2, 3'd4, 8'd100, 0,1);
    add(0,0,0,1, 1, 3'd4, 8'd100, 0,1);
    add(0,0,0,0, 1, 3'd4, 8'd125, 1,0);
    add(0,0,0,0, 3, 3'd4, 8'd125, 0,0);
    // Pending slot cleared by a simultaneous up+down edge
    add(0,1,0,0, 1, 3'd5, 8'd125, 0,1);
    add(0,0,0,0, 2, 3'd5, 8'd125, 0,1);
    add(0,1,0,0, 1, 3'd5, 8'd125, 0,1);
    add(0,0,0,0, 1, 3'd5, 8'd125, 0,1);
    add(0,1,1,0, 1, 3'd5, 8'd125, 0,1);
    add(0,0,0,1, 1, 3'd5, 8'd125, 0,1);
    add(0,0,0,0, 1, 3'd5, 8'd150, 1,0);
    add(0,0,0,0, 3, 3'd5, 8'd150, 0,0);
    // Down to 4, back up to 5, reset while waiting for the boundary with btn_up held
    add(0,0,1,0, 1, 3'd4, 8'd150, 0,1);
    add(0,0,0,0, 2, 3'd4, 8'd150, 0,1);
    add(0,0,0,1, 1, 3'd4, 8'd150, 0,1);
    add(0,0,0,0, 1, 3'd4, 8'd125, 1,0);
    add(0,0,0,0, 1, 3'd4, 8'd125, 0,0);
    add(0,1,0,0, 1, 3'd5, 8'd125, 0,1);
    add(0,0,0,0, 3, 3'd5, 8'd125, 0,1);
    add(1,1,0,0, 1, 3'd0, 8'd0,   0,1);
    add(0,1,0,0, 3, 3'd0, 8'd0,   0,1);
    add(0,1,0,0, 1, 3'd0, 8'd30,  1,0);
    add(0,1,0,0, 4, 3'd0, 8'd30,  0,0);
    add(0,0,0,0, 2, 3'd0, 8'd30,  0,0);
    // Forced apply after 16 boundary-wait cycles
    add(0,1,0,0, 1, 3'd1, 8'd30,  0,1);
    add(0,0,0,0, 2, 3'd1, 8'd30,  0,1);
    add(0,0,0,0,16, 3'd1, 8'd30,  0,1);
    add(0,0,0,0, 1, 3'd1, 8'd50,  1,0);
    add(0,0,0,0, 1, 3'd1, 8'd50,  0,0);
    b4 = vecs.size();

    RESET = 1'b1; btn_up = 1'b0; btn_down = 1'b0; period_end = 1'b0;
    up0 = 1'b0; down0 = 1'b0; pe0 = 1'b0;

    run_rows(0, b1);
    for (int k = 2; k <= 7; k++) step_req(1'b1, 3'(k));
    run_rows(b1, b2);
    for (int k = 6; k >= 0; k--) step_req(1'b0, 3'(k));
    run_rows(b2, b3);
    step_req(1'b1, 3'd1);
    step_req(1'b1, 3'd2);
    run_rows(b3, b4);

    // Timeout disabled: only period_end ends the boundary wait
    chk0("noto_idle", 3'd0, 8'd30, 1'b0, 1'b0);
    up0 = 1'b1;
    tick();
    up0 = 1'b0;
    repeat (40) tick();
    chk0("noto_still_waiting", 3'd1, 8'd30, 1'b0, 1'b1);
    pe0 = 1'b1;
    tick();
    pe0 = 1'b0;
    tick();
    chk0("noto_apply", 3'd1, 8'd50, 1'b1, 1'b0);
    tick();
    chk0("noto_after", 3'd1, 8'd50, 1'b0, 1'b0);
    $display("timeout-disabled instance: idx=%0d per=%0d", num0, per0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
